// File: rtl/mag_pkg.sv
// Shared types and constants for the magnitude window statistics block.
package mag_pkg;

    localparam int unsigned MAG_W        = 8;
    localparam int unsigned WIN_LOG2_DEF = 4;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        PUBLISH
    } win_state_t;

    // The sum of 2^win_log2 samples of data_w bits always fits in data_w+win_log2 bits.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned win_log2);
        return data_w + win_log2;
    endfunction

endpackage

// File: rtl/mag_window_stats_if.sv
// Sample stream, thresholds and statistics outputs of mag_window_stats.
interface mag_window_stats_if
    import mag_pkg::*;
#(
    parameter int unsigned DATA_W   = MAG_W,
    parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF
);
    logic                ena;
    logic                clear;
    logic                mag_valid;
    logic [DATA_W-1:0]   mag_in;
    logic [DATA_W-1:0]   thr_hi;
    logic [DATA_W-1:0]   thr_lo;
    logic [DATA_W-1:0]   avg_out;
    logic [DATA_W-1:0]   max_out;
    logic [DATA_W-1:0]   min_out;
    logic                stats_valid;
    logic                alarm;
    logic [WIN_LOG2-1:0] sample_cnt;

    modport master (
        output ena, clear, mag_valid, mag_in, thr_hi, thr_lo,
        input  avg_out, max_out, min_out, stats_valid, alarm, sample_cnt
    );

    modport slave (
        input  ena, clear, mag_valid, mag_in, thr_hi, thr_lo,
        output avg_out, max_out, min_out, stats_valid, alarm, sample_cnt
    );

endinterface

// File: rtl/mag_hyst_alarm.sv
// Hysteretic threshold alarm, re-evaluated only when a new window average is published.
module mag_hyst_alarm
    import mag_pkg::*;
#(
    parameter int unsigned DATA_W = MAG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_strobe,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_avg,
    input  logic [DATA_W-1:0] i_thr_hi,
    input  logic [DATA_W-1:0] i_thr_lo,
    output logic              o_alarm
);

    logic r_alarm;

    // Set test comes first, so an inverted threshold pair still favours raising the alarm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alarm <= 1'b0;
        end else if (i_clear) begin
            r_alarm <= 1'b0;
        end else if (i_strobe) begin
            if (i_avg >= i_thr_hi) begin
                r_alarm <= 1'b1;
            end else if (i_avg < i_thr_lo) begin
                r_alarm <= 1'b0;
            end
        end
    end

    assign o_alarm = r_alarm;

endmodule

// File: rtl/mag_window_stats.sv
// Windowed mean/max/min of accepted magnitude samples, published once per 2^WIN_LOG2 samples.
module mag_window_stats
    import mag_pkg::*;
#(
    parameter int unsigned DATA_W   = MAG_W,
    parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    mag_window_stats_if.slave  bus
);

    localparam int unsigned         ACC_W    = acc_width(DATA_W, WIN_LOG2);
    localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

    win_state_t          r_state;
    logic [ACC_W-1:0]    r_acc;
    logic [DATA_W-1:0]   r_max;
    logic [DATA_W-1:0]   r_min;
    logic [WIN_LOG2-1:0] r_cnt;
    logic [DATA_W-1:0]   r_avg;
    logic [DATA_W-1:0]   r_omax;
    logic [DATA_W-1:0]   r_omin;
    logic                r_stats_valid;

    logic                w_accept;
    logic                w_last;
    logic [ACC_W-1:0]    w_sum;
    logic [DATA_W-1:0]   w_avg;
    logic [DATA_W-1:0]   w_max;
    logic [DATA_W-1:0]   w_min;
    logic                w_alarm;

    assign w_accept = bus.ena & bus.mag_valid & ~bus.clear;
    assign w_last   = w_accept && (r_cnt == CNT_LAST);
    assign w_sum    = r_acc + ACC_W'(bus.mag_in);
    // Mean is the top DATA_W bits of the window sum (shift by WIN_LOG2).
    assign w_avg    = w_sum[WIN_LOG2 +: DATA_W];
    assign w_max    = (bus.mag_in > r_max) ? bus.mag_in : r_max;
    assign w_min    = (bus.mag_in < r_min) ? bus.mag_in : r_min;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= EMPTY;
            r_acc         <= '0;
            r_max         <= '0;
            r_min         <= '1;
            r_cnt         <= '0;
            r_avg         <= '0;
            r_omax        <= '0;
            r_omin        <= '0;
            r_stats_valid <= 1'b0;
        end else if (!bus.ena) begin
            r_stats_valid <= 1'b0;
        end else if (bus.clear) begin
            r_state       <= EMPTY;
            r_acc         <= '0;
            r_max         <= '0;
            r_min         <= '1;
            r_cnt         <= '0;
            r_stats_valid <= 1'b0;
        end else begin
            r_stats_valid <= w_last;
            if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_acc  <= '0;
                    r_max  <= '0;
                    r_min  <= '1;
                    r_avg  <= w_avg;
                    r_omax <= w_max;
                    r_omin <= w_min;
                end else begin
                    r_acc  <= w_sum;
                    r_max  <= w_max;
                    r_min  <= w_min;
                end
            end
            case (r_state)
                EMPTY:   if (w_accept) r_state <= FILLING;
                FILLING: if (w_last)   r_state <= PUBLISH;
                PUBLISH: r_state <= w_accept ? FILLING : EMPTY;
                default: r_state <= EMPTY;
            endcase
        end
    end

    mag_hyst_alarm #(
        .DATA_W (DATA_W)
    ) u_alarm (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_strobe (w_last),
        .i_clear  (bus.ena & bus.clear),
        .i_avg    (w_avg),
        .i_thr_hi (bus.thr_hi),
        .i_thr_lo (bus.thr_lo),
        .o_alarm  (w_alarm)
    );

    assign bus.avg_out     = r_avg;
    assign bus.max_out     = r_omax;
    assign bus.min_out     = r_omin;
    assign bus.stats_valid = r_stats_valid;
    assign bus.alarm       = w_alarm;
    assign bus.sample_cnt  = r_cnt;

endmodule

// File: tb/tb_mag_window_stats.sv
// Directed bench for mag_window_stats: queue-based window model checked every cycle plus literal expectations.
module tb_mag_window_stats;
    import mag_pkg::*;

    localparam int unsigned WIN = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mag_window_stats_if #(.DATA_W(8), .WIN_LOG2(4)) bus_if ();

    mag_window_stats #(.DATA_W(8), .WIN_LOG2(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: collect accepted samples in a queue; a full queue is one window.
    int q[$];
    int m_avg, m_max, m_min, m_sv, m_alarm;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_avg = 0; m_max = 0; m_min = 0; m_sv = 0; m_alarm = 0;
        end else if (bus_if.ena) begin
            m_sv = 0;
            if (bus_if.clear) begin
                q.delete();
                m_alarm = 0;
            end else if (bus_if.mag_valid) begin
                q.push_back(int'(bus_if.mag_in));
                if (q.size() == WIN) begin
                    int sum, mx, mn;
                    sum = 0; mx = 0; mn = 255;
                    foreach (q[i]) begin
                        sum += q[i];
                        if (q[i] > mx) mx = q[i];
                        if (q[i] < mn) mn = q[i];
                    end
                    m_avg = sum / WIN;
                    m_max = mx;
                    m_min = mn;
                    m_sv  = 1;
                    if (m_avg >= int'(bus_if.thr_hi))     m_alarm = 1;
                    else if (m_avg < int'(bus_if.thr_lo)) m_alarm = 0;
                    q.delete();
                end
            end
        end else begin
            m_sv = 0;
        end
    end

    int cyc = 0, pulses = 0, last_pulse = -100, gap = 0;

    always @(negedge clk) begin
        cyc++;
        check("cyc_avg",   bus_if.avg_out,     m_avg);
        check("cyc_max",   bus_if.max_out,     m_max);
        check("cyc_min",   bus_if.min_out,     m_min);
        check("cyc_valid", bus_if.stats_valid, m_sv);
        check("cyc_alarm", bus_if.alarm,       m_alarm);
        check("cyc_cnt",   bus_if.sample_cnt,  q.size());
        if (bus_if.stats_valid === 1'b1) begin
            pulses++;
            gap        = cyc - last_pulse;
            last_pulse = cyc;
        end
    end

    task automatic drive(input logic v, input logic [7:0] d,
                         input logic e = 1'b1, input logic c = 1'b0);
        @(negedge clk);
        bus_if.ena       = e;
        bus_if.clear     = c;
        bus_if.mag_valid = v;
        bus_if.mag_in    = d;
    endtask

    task automatic wait_pulse(input string tag, input int a, input int mx,
                              input int mn, input int al);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            bus_if.ena = 1'b1; bus_if.clear = 1'b0; bus_if.mag_valid = 1'b0;
            if (bus_if.stats_valid === 1'b1) begin
                seen = 1;
                check({tag, "_avg"},   bus_if.avg_out, a);
                check({tag, "_max"},   bus_if.max_out, mx);
                check({tag, "_min"},   bus_if.min_out, mn);
                check({tag, "_alarm"}, bus_if.alarm,   al);
            end
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int p0;
        bus_if.ena = 1'b0; bus_if.clear = 1'b0; bus_if.mag_valid = 1'b0;
        bus_if.mag_in = '0; bus_if.thr_hi = 8'd200; bus_if.thr_lo = 8'd150;

        repeat (3) @(negedge clk);
        check("rst_avg",   bus_if.avg_out, 0);
        check("rst_max",   bus_if.max_out, 0);
        check("rst_min",   bus_if.min_out, 0);
        check("rst_valid", bus_if.stats_valid, 0);
        check("rst_alarm", bus_if.alarm, 0);
        check("rst_cnt",   bus_if.sample_cnt, 0);
        rst_n = 1'b1;

        // Constant window
        repeat (16) drive(1'b1, 8'd100);
        wait_pulse("w100", 100, 100, 100, 0);
        check("w100_cnt", bus_if.sample_cnt, 0);

        // Ramp with gaps and a mid-window freeze (valid held high while frozen)
        drive(1'b0, 8'd0);
        p0 = pulses;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i));
            if (i < 15) drive(1'b0, 8'd0);
            if (i == 7) repeat (5) drive(1'b1, 8'd99, 1'b0);
        end
        wait_pulse("ramp", 7, 15, 0, 0);
        drive(1'b0, 8'd0);
        check("ramp_pulses", pulses - p0, 1);

        // Full-scale window then all-zero window back to back
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, (i < 16) ? 8'd255 : 8'd0);
            if (i == 16) begin
                check("full_valid", bus_if.stats_valid, 1);
                check("full_avg",   bus_if.avg_out, 255);
                check("full_max",   bus_if.max_out, 255);
                check("full_min",   bus_if.min_out, 255);
                check("full_alarm", bus_if.alarm, 1);
            end
        end
        wait_pulse("zero", 0, 0, 0, 0);
        drive(1'b0, 8'd0);
        check("b2b_gap", gap, 16);

        // Hysteresis: 210 set, 170 hold, 149 release, 160 hold
        repeat (16) drive(1'b1, 8'd210);
        wait_pulse("hys210", 210, 210, 210, 1);
        repeat (16) drive(1'b1, 8'd170);
        wait_pulse("hys170", 170, 170, 170, 1);
        repeat (16) drive(1'b1, 8'd149);
        wait_pulse("hys149", 149, 149, 149, 0);
        repeat (16) drive(1'b1, 8'd160);
        wait_pulse("hys160", 160, 160, 160, 0);

        // Clear mid-window; the sample presented with clear is dropped
        drive(1'b0, 8'd0);
        p0 = pulses;
        repeat (10) drive(1'b1, 8'd80);
        drive(1'b1, 8'd80, 1'b1, 1'b1);
        repeat (15) drive(1'b1, 8'd50);
        check("clr_nopulse", pulses - p0, 0);
        check("clr_hold_avg", bus_if.avg_out, 160);
        check("clr_hold_max", bus_if.max_out, 160);
        drive(1'b1, 8'd50);
        wait_pulse("postclr", 50, 50, 50, 0);

        // Clear on the final sample suppresses the publish
        drive(1'b0, 8'd0);
        p0 = pulses;
        repeat (15) drive(1'b1, 8'd70);
        drive(1'b1, 8'd70, 1'b1, 1'b1);
        repeat (3) drive(1'b0, 8'd0);
        check("clr_last_nopulse", pulses - p0, 0);
        check("clr_last_cnt", bus_if.sample_cnt, 0);
        check("clr_last_avg", bus_if.avg_out, 50);

        // Asynchronous reset mid-window
        repeat (7) drive(1'b1, 8'd30);
        @(negedge clk);
        bus_if.mag_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_avg",   bus_if.avg_out, 0);
        check("arst_max",   bus_if.max_out, 0);
        check("arst_min",   bus_if.min_out, 0);
        check("arst_cnt",   bus_if.sample_cnt, 0);
        check("arst_valid", bus_if.stats_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (16) drive(1'b1, 8'd30);
        wait_pulse("post_rst", 30, 30, 30, 0);
        repeat (2) drive(1'b0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
